// File: rtl/oven_pkg.sv
// Shared types and widths for the oven cook-cycle executor.
package oven_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREHEAT = 3'd1,
    COOK    = 3'd2,
    PAUSE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int LVL_W = 2;
  localparam int REM_W = 8;

  // Parameter limits keep every product inside 8 bits.
  function automatic logic [REM_W-1:0] phase_load(input logic [LVL_W-1:0] k,
                                                  input logic [REM_W-1:0] sec);
    return REM_W'(k) * sec;
  endfunction

endpackage

// File: rtl/oven_cook_timer_if.sv
// Panel-side command and status bundle of the cook timer.
interface oven_cook_timer_if;
  import oven_pkg::*;

  logic             start;
  logic [LVL_W-1:0] temp;
  logic [LVL_W-1:0] temp_time;
  logic             door_open;
  logic             cancel;
  logic [LVL_W-1:0] heater_level;
  logic             busy;
  logic [REM_W-1:0] remaining;
  logic             done;
  logic             buzzer;

  modport master (
    output start, temp, temp_time, door_open, cancel,
    input  heater_level, busy, remaining, done, buzzer
  );

  modport slave (
    input  start, temp, temp_time, door_open, cancel,
    output heater_level, busy, remaining, done, buzzer
  );

endinterface

// File: rtl/oven_tick_gen.sv
// One-second prescaler: tick is high on the last cycle of each second.
module oven_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/oven_cook_timer.sv
// Cook-cycle executor: preheat, timed cook, door pause, cancel and buzzer.
module oven_cook_timer
  import oven_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int PREHEAT_SEC = 5,
  parameter int STEP_SEC    = 30,
  parameter int BEEP_SEC    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  oven_cook_timer_if.slave   bus
);

  state_t           state, nxt, saved, saved_n;
  logic [LVL_W-1:0] lt, lt_n, ltt, ltt_n;
  logic [REM_W-1:0] rem, rem_n, beep, beep_n;
  logic             tick, tick_en, accept;

  assign accept  = bus.start && (bus.temp != '0) && (bus.temp_time != '0) && !bus.door_open;
  assign tick_en = (state == PREHEAT) || (state == COOK) || (state == DONE);

  // Clearing on every state change restarts a partial second after a pause.
  oven_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (nxt != state),
    .tick (tick)
  );

  always_comb begin
    nxt     = state;
    saved_n = saved;
    lt_n    = lt;
    ltt_n   = ltt;
    rem_n   = rem;
    beep_n  = beep;
    if (bus.cancel) begin
      nxt    = IDLE;
      rem_n  = '0;
      beep_n = '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          nxt   = PREHEAT;
          lt_n  = bus.temp;
          ltt_n = bus.temp_time;
          rem_n = phase_load(bus.temp, REM_W'(PREHEAT_SEC));
        end
        PREHEAT, COOK: begin
          if (bus.door_open) begin
            nxt     = PAUSE;
            saved_n = state;
          end else if (tick) begin
            if (rem <= 8'd1) begin
              if (state == PREHEAT) begin
                nxt   = COOK;
                rem_n = phase_load(ltt, REM_W'(STEP_SEC));
              end else begin
                nxt    = DONE;
                rem_n  = '0;
                beep_n = REM_W'(BEEP_SEC);
              end
            end else begin
              rem_n = rem - 8'd1;
            end
          end
        end
        PAUSE: if (!bus.door_open) nxt = saved;
        DONE: begin
          if (tick && (beep <= 8'd1)) begin
            nxt    = IDLE;
            beep_n = '0;
          end else if (accept) begin
            nxt    = PREHEAT;
            beep_n = '0;
            lt_n   = bus.temp;
            ltt_n  = bus.temp_time;
            rem_n  = phase_load(bus.temp, REM_W'(PREHEAT_SEC));
          end else if (tick) begin
            beep_n = beep - 8'd1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  assign bus.remaining = rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      saved            <= IDLE;
      lt               <= '0;
      ltt              <= '0;
      rem              <= '0;
      beep             <= '0;
      bus.heater_level <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.buzzer       <= 1'b0;
    end else begin
      state            <= nxt;
      saved            <= saved_n;
      lt               <= lt_n;
      ltt              <= ltt_n;
      rem              <= rem_n;
      beep             <= beep_n;
      bus.heater_level <= ((nxt == PREHEAT) || (nxt == COOK)) ? lt_n : '0;
      bus.busy         <= (nxt == PREHEAT) || (nxt == COOK) || (nxt == PAUSE);
      bus.done         <= (nxt == DONE) && (state != DONE);
      bus.buzzer       <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_oven_cook_timer.sv
// Bench for oven_cook_timer: table vectors, corner sequences, random run vs cycle-budget model.
module tb_oven_cook_timer;
  import oven_pkg::*;

  localparam int TD = 4;
  localparam int PS = 1;
  localparam int SS = 2;
  localparam int BS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oven_cook_timer_if bus();

  oven_cook_timer #(.TICK_DIV(TD), .PREHEAT_SEC(PS), .STEP_SEC(SS), .BEEP_SEC(BS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each phase is a budget of clock cycles; the displayed
  // seconds are that budget rounded up to whole ticks.
  typedef enum int {M_IDLE, M_PRE, M_COOK, M_PAUSE, M_DONE} mphase_t;
  mphase_t ms, msaved;
  int m_lt, m_ltt, m_cyc, m_beep;
  bit m_done;

  function automatic int ceil_sec(int c);
    return (c + TD - 1) / TD;
  endfunction

  function automatic void model_reset();
    ms = M_IDLE; msaved = M_IDLE;
    m_lt = 0; m_ltt = 0; m_cyc = 0; m_beep = 0; m_done = 0;
  endfunction

  function automatic void model_load();
    m_lt  = int'(bus.temp);
    m_ltt = int'(bus.temp_time);
    ms    = M_PRE;
    m_cyc = m_lt * PS * TD;
  endfunction

  function automatic void model_step();
    bit acc;
    acc = bus.start && (bus.temp != 0) && (bus.temp_time != 0) && !bus.door_open;
    m_done = 0;
    if (bus.cancel) begin
      ms = M_IDLE; m_cyc = 0; m_beep = 0;
    end else begin
      case (ms)
        M_IDLE: if (acc) model_load();
        M_PRE, M_COOK: begin
          if (bus.door_open) begin
            msaved = ms; ms = M_PAUSE;
          end else begin
            m_cyc--;
            if (m_cyc <= 0) begin
              if (ms == M_PRE) begin
                ms = M_COOK; m_cyc = m_ltt * SS * TD;
              end else begin
                ms = M_DONE; m_cyc = 0; m_beep = BS * TD; m_done = 1;
              end
            end
          end
        end
        M_PAUSE: if (!bus.door_open) begin
          ms = msaved; m_cyc = ceil_sec(m_cyc) * TD;
        end
        M_DONE: begin
          m_beep--;
          if (m_beep == 0) ms = M_IDLE;
          else if (acc) model_load();
        end
        default: ms = M_IDLE;
      endcase
    end
  endfunction

  function automatic logic [12:0] model_out();
    logic [1:0] h; logic b; logic [7:0] r; logic z;
    h = (ms == M_PRE || ms == M_COOK) ? 2'(m_lt) : 2'd0;
    b = (ms == M_PRE || ms == M_COOK || ms == M_PAUSE);
    r = (ms == M_PRE || ms == M_COOK || ms == M_PAUSE) ? 8'(ceil_sec(m_cyc)) : 8'd0;
    z = (ms == M_DONE);
    return {h, b, r, m_done, z};
  endfunction

  function automatic logic [12:0] dut_out();
    return {bus.heater_level, bus.busy, bus.remaining, bus.done, bus.buzzer};
  endfunction

  task automatic check_vec(string name, logic [12:0] exp);
    logic [12:0] act;
    act = dut_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got heater=%0d busy=%0d rem=%0d done=%0d buzzer=%0d, expected heater=%0d busy=%0d rem=%0d done=%0d buzzer=%0d",
               name, $time, act[12:11], act[10], act[9:2], act[1], act[0],
               exp[12:11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_in(logic s, logic [1:0] t, logic [1:0] tt, logic d, logic c);
    bus.start = s; bus.temp = t; bus.temp_time = tt; bus.door_open = d; bus.cancel = c;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_model(mphase_t target, int rem_target, int budget, string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cyc();
      check_vec(name, model_out());
      if (ms == target && (rem_target < 0 || ceil_sec(m_cyc) == rem_target)) hit = 1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no match in %0d cycles, expected phase %0d", name, budget, target);
    end
  endtask

  typedef struct {
    logic       start;
    logic [1:0] temp;
    logic [1:0] tt;
    logic       door;
    logic       cancel;
    logic [1:0] h;
    logic       b;
    logic [7:0] r;
    logic       d;
    logic       z;
    int         n;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic [1:0] t, logic [1:0] tt, logic dr, logic c,
                              logic [1:0] h, logic b, logic [7:0] r, logic d, logic z, int n);
    vec_t v;
    v.start = s; v.temp = t; v.tt = tt; v.door = dr; v.cancel = c;
    v.h = h; v.b = b; v.r = r; v.d = d; v.z = z; v.n = n;
    return v;
  endfunction

  initial begin
    set_in(0, 0, 0, 0, 0);
    model_reset();

    // full cycle temp=2 time=1, then rejected starts from IDLE
    tbl.push_back(mk(1, 2, 1, 0, 0,  2, 1, 8'd2, 0, 0, 1));
    tbl.push_back(mk(0, 3, 3, 0, 0,  2, 1, 8'd2, 0, 0, 3));
    tbl.push_back(mk(0, 3, 3, 0, 0,  2, 1, 8'd1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,  2, 1, 8'd2, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,  2, 1, 8'd1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 8'd0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 8'd0, 0, 1, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 8'd0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0, 8'd0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 1, 1, 0,  0, 0, 8'd0, 0, 0, 2));
    tbl.push_back(mk(1, 2, 0, 0, 0,  0, 0, 8'd0, 0, 0, 1));

    #1;
    check_vec("reset", 13'd0);
    #11 rst_n = 1'b1;

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        set_in((j == 0) ? tbl[k].start : 1'b0, tbl[k].temp, tbl[k].tt, tbl[k].door, tbl[k].cancel);
        cyc();
        check_vec("tbl", {tbl[k].h, tbl[k].b, tbl[k].r, tbl[k].d, tbl[k].z});
      end
    end

    // start during COOK is ignored
    set_in(1, 3, 2, 0, 0);
    cyc();
    check_vec("run_start", model_out());
    set_in(0, 0, 0, 0, 0);
    wait_model(M_COOK, -1, 30, "to_cook");
    set_in(1, 1, 1, 0, 0);
    cyc();
    check_int("cook_start_heater", int'(bus.heater_level), 3);
    check_int("cook_start_rem", int'(bus.remaining), 4);
    set_in(0, 0, 0, 0, 0);

    // door pause at COOK remaining=3
    wait_model(M_COOK, 3, 10, "to_rem3");
    set_in(0, 0, 0, 1, 0);
    cyc();
    check_int("pause_heater", int'(bus.heater_level), 0);
    check_int("pause_rem", int'(bus.remaining), 3);
    for (int i = 0; i < 9; i++) begin
      cyc();
      check_int("pause_hold_rem", int'(bus.remaining), 3);
    end
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) check_int("resume_heater", int'(bus.heater_level), 3);
      check_int("resume_rem", int'(bus.remaining), (i < 4) ? 3 : 2);
    end

    // cancel beats door in the same cycle
    set_in(0, 0, 0, 1, 1);
    cyc();
    check_vec("cancel_door", 13'd0);
    set_in(0, 0, 0, 0, 0);
    cyc();
    check_vec("cancel_idle", 13'd0);

    // restart from DONE
    set_in(1, 1, 1, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    wait_model(M_DONE, -1, 40, "to_done");
    cyc();
    check_int("done_buzzer", int'(bus.buzzer), 1);
    set_in(1, 1, 1, 0, 0);
    cyc();
    check_vec("done_restart", {2'd1, 1'b1, 8'd1, 1'b0, 1'b0});
    set_in(0, 0, 0, 0, 0);

    // asynchronous reset mid-PREHEAT
    cyc();
    #3 rst_n = 1'b0;
    #1;
    check_vec("async_reset", 13'd0);
    model_reset();
    #2 rst_n = 1'b1;
    set_in(0, 2, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_vec("post_reset_idle", 13'd0);
    end
    set_in(1, 2, 2, 0, 0);
    cyc();
    check_vec("post_reset_start", {2'd2, 1'b1, 8'd2, 1'b0, 1'b0});

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic dr;
      dr = bus.door_open;
      if ($urandom_range(0, 11) == 0) dr = ~dr;
      set_in($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             dr, $urandom_range(0, 49) == 0);
      cyc();
      check_vec("rand", model_out());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oven_cook_timer.md
# oven_cook_timer

Cook-cycle executor that sits directly downstream of the oven front-panel controller. It latches the selected heat level (`temp`) and duration code (`temp_time`) on the controller's one-cycle start pulse. It then runs a preheat phase and a timed cook phase, and drives the heater level. It finishes with a done pulse and a timed buzzer, and supports door-open pause and cancel.

## Interface
- `TICK_DIV`, 1000: clock cycles per one-second tick; ≥2.
- `PREHEAT_SEC`, 5: preheat seconds per heat level; `3*PREHEAT_SEC` ≤ 255.
- `STEP_SEC`, 30: cook seconds per duration-code unit; `3*STEP_SEC` ≤ 255.
- `BEEP_SEC`, 3: buzzer duration in seconds; 1..255.
- Clocking and reset (already decided): `clk`, one clock; reset `rst_n`, asynchronous, active-low.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle start pulse from the panel controller.
- `temp`  in  2  heat level, 0..3.
- `temp_time`  in  2  duration code, 0..3.
- `door_open`  in  1  level, 1 = door open.
- `cancel`  in  1  level or pulse, abort request.
- `heater_level`  out  2  heater drive, 0 = off.
- `busy`  out  1  high in PREHEAT, COOK and PAUSE.
- `remaining`  out  8  seconds left in the current phase.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `buzzer`  out  1  high throughout DONE.

## Operation
- States: IDLE, PREHEAT, COOK, PAUSE, DONE.
- **Reset:** state IDLE; all outputs 0; latched temp/time, saved state and prescaler cleared.
- **Start acceptance:** `start` is accepted in IDLE or DONE only, and only if `temp`≠0, `temp_time`≠0 and `door_open`=0. Otherwise it is ignored. `start` in PREHEAT, COOK or PAUSE is always ignored.
- **On accept:**
  - Latch `temp` → `lt` and `temp_time` → `ltt`.
  - Go to PREHEAT with `remaining` = `lt*PREHEAT_SEC`.
  - Input changes after the accept are ignored until the next accept.
- **PREHEAT:**
  - `heater_level` = `lt`.
  - Each tick decrements `remaining`.
  - A tick with `remaining`=1 → COOK with `remaining` = `ltt*STEP_SEC`.
- **COOK:**
  - `heater_level` = `lt`.
  - A tick with `remaining`=1 → DONE with `remaining`=0.
- **PAUSE:**
  - Entered from PREHEAT or COOK when `door_open`=1; that state is saved.
  - `heater_level`=0; `remaining` holds.
  - When `door_open`=0, return to the saved state.
- **DONE:**
  - `heater_level`=0; `buzzer`=1 for `BEEP_SEC` ticks, then IDLE.
  - `door_open` has no effect in DONE.
  - An accepted `start` aborts the beep and goes to PREHEAT.
- **Cancel:** `cancel`=1 in any state → IDLE next cycle, with `heater_level`, `buzzer` and `remaining` = 0.
- **Priority, same cycle:** `cancel` > `door_open` > tick > `start`.
- **Arithmetic:** all phase loads are 8-bit unsigned products; the parameter limits above guarantee no overflow. `remaining` never wraps below 0.

## Timing
- Accept at edge N → at N+1: `busy`=1, `heater_level`=`lt`, `remaining` loaded.
- **Prescaler:**
  - Counts 0..`TICK_DIV`-1 only in PREHEAT, COOK and DONE.
  - A tick occurs when the count is `TICK_DIV`-1.
  - The count clears on every state entry, including resume from PAUSE. A partial second is therefore restarted after a pause.
- **Phase length:** exactly `remaining*TICK_DIV` cycles from entry to the next state. DONE lasts `BEEP_SEC*TICK_DIV` cycles.
- **PAUSE entry:** `door_open` high at edge N → `heater_level`=0 at N+1.
- **PAUSE exit:** `door_open` low at edge N → the saved state resumes at N+1.
- **`done`:** high for exactly the first cycle of DONE.
- **Registering:** all outputs are registered; no combinational input→output path.

## Structure
- **Shared package `oven_pkg`:**
  - State enum: IDLE=0, PREHEAT=1, COOK=2, PAUSE=3, DONE=4 (3-bit).
  - Heat-level and time-code width constants (2).
  - `remaining` width (8).
- **Sub-module `oven_tick_gen`:** prescaler with inputs `clk`, `rst_n`, `en`, `clr` and a one-cycle `tick` output.
- **Top level:** FSM, latches and the `remaining` counter.

## Test plan
- Parameters for all scenarios: `TICK_DIV`=4, `PREHEAT_SEC`=1, `STEP_SEC`=2, `BEEP_SEC`=2.
- **Full cycle:** `temp`=2, `temp_time`=1, `start` pulse → PREHEAT 8 cycles (heater 2, `remaining` 2→1) → COOK 8 cycles (`remaining` 2→1) → `done` for 1 cycle, `buzzer` for 8 cycles → IDLE with all outputs 0.
- **Rejected starts:**
  - `start` with `temp`=0 → stays IDLE.
  - `start` with `door_open`=1 → stays IDLE.
  - `start` during COOK → no change.
- **Door pause:**
  - Setup: `temp`=3, `temp_time`=2, run started.
  - Stimulus: door opened for 10 cycles at COOK `remaining`=3.
  - Response: `heater_level` 0 in the following cycle and `remaining` holds at 3. On close, COOK resumes at heater 3 with a full 4-cycle tick before `remaining` reaches 2.
- **Priority and restart:**
  - `cancel` and `door_open` rising in the same COOK cycle → IDLE next cycle, with `heater_level`=0 and `remaining`=0.
  - `start` in DONE (`temp`=1, `temp_time`=1) → PREHEAT with `remaining`=1 and `buzzer`=0.
- **Reset mid-operation:** `rst_n` low asynchronously mid-PREHEAT → all outputs 0 immediately, before any clock edge. After release, the block stays IDLE until a valid `start`.
